exu_lsu_ctrl: RTL and testbench

//  Load/store sequencer between the ALU/AGU stage and the data bus.
//  - Takes the single-cycle memory request the ALU produces (address, byte enables, write data, load type, rd).
//  - Stalls the pipeline while it runs one bus transaction: valid/ready request phase, then a response phase.
//  - Aligns and sign/zero-extends load data, writes it back to rd.
//  - Flags misaligned accesses, bus errors and timeouts.

---
 rtl/exu_lsu_pkg.sv | 24 ++
 rtl/exu_lsu_ldext.sv | 20 ++
 rtl/exu_lsu_ctrl.sv | 130 +++++++++++++
 tb/tb_exu_lsu_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/exu_lsu_pkg.sv
// exu_lsu_pkg: shared encodings for the load/store sequencer.
// Holds the FSM state type, load-type and byte-enable constants,
// and the misalignment rule.
package exu_lsu_pkg;

    typedef enum logic [1:0] {IDLE, REQ, RSP, DONE} state_t;

    localparam logic [3:0] RDT_B  = 4'b0001;
    localparam logic [3:0] RDT_H  = 4'b0010;
    localparam logic [3:0] RDT_W  = 4'b0100;
    localparam logic [3:0] RDT_U  = 4'b1000;

    localparam logic [3:0] BE_W   = 4'b1111;
    localparam logic [3:0] BE_HLO = 4'b0011;
    localparam logic [3:0] BE_HHI = 4'b1100;

    // Stores are sized by their lane-shifted byte enables; loads by rdtype.
    function automatic logic misaligned(input logic store, input logic [3:0] be,
                                        input logic [3:0] rdtype, input logic [1:0] off);
        return ((store ? (be == BE_HLO || be == BE_HHI) : (rdtype & RDT_H) != 4'b0) & off[0])
             | ((store ? (be == BE_W) : (rdtype & RDT_W) != 4'b0) & (off != 2'b00));
    endfunction

endpackage

// File: rtl/exu_lsu_ldext.sv
// exu_lsu_ldext: load data alignment and extension.
// Ports: rdata (bus word), offset (byte address bits [1:0]),
//        rdtype ([2:0] one-hot B/H/W, [3] unsigned), data (extended result).
module exu_lsu_ldext (
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [3:0]  rdtype,
    output logic [31:0] data
);
    logic [31:0] sh;
    logic        sx;
    always_comb begin
        sh   = rdata >> {offset, 3'b000};
        sx   = ~rdtype[3];
        // one-hot OR-mux; an empty size field yields zero
        data = ({32{rdtype[0]}} & {{24{sx & sh[7]}}, sh[7:0]})
             | ({32{rdtype[1]}} & {{16{sx & sh[15]}}, sh[15:0]})
             | ({32{rdtype[2]}} & sh);
    end
endmodule

// File: rtl/exu_lsu_ctrl.sv
// exu_lsu_ctrl: load/store sequencer between the ALU/AGU stage and the data bus.
// Ports: i_clk/i_rst (async high reset); i_mem_* / i_data_be / i_rd_* request
//        from the ALU; o_stall back-pressure; o_bus_* / i_bus_* valid-ready
//        request and response phases; o_wb_* rd writeback; o_misalign_exc and
//        o_bus_err_exc one-cycle exception pulses.
module exu_lsu_ctrl
    import exu_lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_mem_wen,
    input  logic        i_mem_ren,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_data_be,
    input  logic [3:0]  i_mem_rdtype,
    input  logic        i_rd_wen,
    input  logic [4:0]  i_rd_addr,
    output logic        o_stall,
    output logic        o_bus_req_valid,
    input  logic        i_bus_req_ready,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_be,
    input  logic        i_bus_rsp_valid,
    input  logic [31:0] i_bus_rsp_rdata,
    input  logic        i_bus_rsp_err,
    output logic        o_wb_valid,
    output logic [4:0]  o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic        o_misalign_exc,
    output logic        o_bus_err_exc
);
    localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    state_t               state;
    logic [TIMEOUT_W-1:0] cnt;
    logic [1:0]           off_q;
    logic [3:0]           rdtype_q;
    logic                 rd_wen_q;
    logic [31:0]          rdata_q;
    logic                 req;
    logic                 misalign;
    logic                 timeout;

    assign req      = i_mem_wen | i_mem_ren;
    assign misalign = misaligned(i_mem_wen, i_data_be, i_mem_rdtype, i_mem_addr[1:0]);
    // >= rather than == so a handshake in the last REQ cycle still times out in RSP
    assign timeout  = cnt >= CNT_LAST;
    assign o_stall  = (state == IDLE && req) || state == REQ || state == RSP;

    exu_lsu_ldext u_ldext (
        .rdata  (rdata_q),
        .offset (off_q),
        .rdtype (rdtype_q),
        .data   (o_wb_data)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state           <= IDLE;
            cnt             <= '0;
            off_q           <= '0;
            rdtype_q        <= '0;
            rd_wen_q        <= 1'b0;
            rdata_q         <= '0;
            o_bus_req_valid <= 1'b0;
            o_bus_we        <= 1'b0;
            o_bus_addr      <= '0;
            o_bus_wdata     <= '0;
            o_bus_be        <= '0;
            o_wb_valid      <= 1'b0;
            o_wb_addr       <= '0;
            o_misalign_exc  <= 1'b0;
            o_bus_err_exc   <= 1'b0;
        end else begin
            o_wb_valid     <= 1'b0;
            o_misalign_exc <= 1'b0;
            o_bus_err_exc  <= 1'b0;
            case (state)
                IDLE: if (req) begin
                    // wen wins when both are set: the access is a store
                    o_bus_we    <= i_mem_wen;
                    o_bus_addr  <= {i_mem_addr[31:2], 2'b00};
                    o_bus_wdata <= i_mem_wdata;
                    o_bus_be    <= i_mem_wen ? i_data_be : BE_W;
                    off_q       <= i_mem_addr[1:0];
                    rdtype_q    <= i_mem_rdtype;
                    rd_wen_q    <= i_rd_wen;
                    o_wb_addr   <= i_rd_addr;
                    if (misalign) begin
                        state          <= DONE;
                        o_misalign_exc <= 1'b1;
                    end else begin
                        state           <= REQ;
                        o_bus_req_valid <= 1'b1;
                        cnt             <= '0;
                    end
                end
                REQ: if (i_bus_req_ready) begin
                    o_bus_req_valid <= 1'b0;
                    state           <= RSP;
                    cnt             <= cnt + 1'b1;
                end else if (timeout) begin
                    o_bus_req_valid <= 1'b0;
                    state           <= DONE;
                    o_bus_err_exc   <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                RSP: if (i_bus_rsp_valid) begin
                    rdata_q       <= i_bus_rsp_rdata;
                    state         <= DONE;
                    o_bus_err_exc <= i_bus_rsp_err;
                    o_wb_valid    <= ~o_bus_we & rd_wen_q & (|o_wb_addr) & ~i_bus_rsp_err;
                end else if (timeout) begin
                    state         <= DONE;
                    o_bus_err_exc <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_exu_lsu_ctrl.sv
// tb_exu_lsu_ctrl: table-driven, scoreboarded bench for exu_lsu_ctrl.
module tb_exu_lsu_ctrl;
    import exu_lsu_pkg::*;

    typedef struct {
        logic        wen;
        logic        ren;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [3:0]  rdt;
        logic        rdw;
        logic [4:0]  rd;
        logic [31:0] rdata;
        logic        err;
        int          wait_n;
        logic        junk;
        logic [31:0] baddr;
        logic        we;
        logic [3:0]  bbe;
        int          nreq;
        int          nstall;
        logic        wb;
        logic [31:0] wdat;
        logic        mis;
        logic        berr;
    } vec_t;

    typedef struct {
        logic        wb;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        mis;
        logic        berr;
        int          nreq;
        int          nstall;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_wen, mem_ren, rd_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  data_be, mem_rdtype;
    logic [4:0]  rd_addr;
    logic        stall, bus_req_valid, bus_req_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_rsp_valid, bus_rsp_err;
    logic [31:0] bus_rsp_rdata;
    logic        wb_valid, misalign_exc, bus_err_exc;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;

    logic        t_stall, t_bus_req_valid, t_bus_we, t_wb_valid, t_misalign_exc, t_bus_err_exc;
    logic [31:0] t_bus_addr, t_bus_wdata, t_wb_data;
    logic [3:0]  t_bus_be;
    logic [4:0]  t_wb_addr;
    logic        t_ready = 1'b0;
    logic        t_rsp_valid = 1'b0;
    logic        t_err = 1'b0;
    logic [31:0] t_rdata = 32'h0;

    vec_t vecs[15];
    exp_t sb[$];
    int   total = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    exu_lsu_ctrl dut (
        .i_clk(clk), .i_rst(rst),
        .i_mem_wen(mem_wen), .i_mem_ren(mem_ren), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .i_data_be(data_be), .i_mem_rdtype(mem_rdtype),
        .i_rd_wen(rd_wen), .i_rd_addr(rd_addr),
        .o_stall(stall), .o_bus_req_valid(bus_req_valid), .i_bus_req_ready(bus_req_ready),
        .o_bus_we(bus_we), .o_bus_addr(bus_addr), .o_bus_wdata(bus_wdata), .o_bus_be(bus_be),
        .i_bus_rsp_valid(bus_rsp_valid), .i_bus_rsp_rdata(bus_rsp_rdata), .i_bus_rsp_err(bus_rsp_err),
        .o_wb_valid(wb_valid), .o_wb_addr(wb_addr), .o_wb_data(wb_data),
        .o_misalign_exc(misalign_exc), .o_bus_err_exc(bus_err_exc)
    );

    // Short-timeout instance whose bus never answers.
    exu_lsu_ctrl #(.TIMEOUT_CYCLES(4), .TIMEOUT_W(3)) dut_to (
        .i_clk(clk), .i_rst(rst),
        .i_mem_wen(mem_wen), .i_mem_ren(mem_ren), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .i_data_be(data_be), .i_mem_rdtype(mem_rdtype),
        .i_rd_wen(rd_wen), .i_rd_addr(rd_addr),
        .o_stall(t_stall), .o_bus_req_valid(t_bus_req_valid), .i_bus_req_ready(t_ready),
        .o_bus_we(t_bus_we), .o_bus_addr(t_bus_addr), .o_bus_wdata(t_bus_wdata), .o_bus_be(t_bus_be),
        .i_bus_rsp_valid(t_rsp_valid), .i_bus_rsp_rdata(t_rdata), .i_bus_rsp_err(t_err),
        .o_wb_valid(t_wb_valid), .o_wb_addr(t_wb_addr), .o_wb_data(t_wb_data),
        .o_misalign_exc(t_misalign_exc), .o_bus_err_exc(t_bus_err_exc)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic run(input vec_t v, input int idx);
        exp_t e;
        int   nreq = 0;
        int   nstall = 0;
        int   bad = 0;
        logic hs = 1'b0;
        logic done = 1'b0;
        @(negedge clk);
        mem_wen = v.wen; mem_ren = v.ren; mem_addr = v.addr; mem_wdata = v.wdata;
        data_be = v.be; mem_rdtype = v.rdt; rd_wen = v.rdw; rd_addr = v.rd;
        e = '{v.wb, v.rd, v.wdat, v.mis, v.berr, v.nreq, v.nstall};
        sb.push_back(e);
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
            if (!stall) done = 1'b1;
            else begin
                nstall++;
                if (bus_req_valid) begin
                    nreq++;
                    if (bus_addr !== v.baddr || bus_we !== v.we || bus_be !== v.bbe ||
                        (v.we && bus_wdata !== v.wdata)) bad++;
                    bus_req_ready = nreq > v.wait_n;
                    if (v.junk) begin
                        bus_rsp_valid = 1'b1; bus_rsp_rdata = ~v.rdata; bus_rsp_err = 1'b1;
                    end
                end else if (hs) begin
                    bus_rsp_valid = 1'b1; bus_rsp_rdata = v.rdata; bus_rsp_err = v.err;
                end
                hs = bus_req_valid && bus_req_ready;
                @(negedge clk);
            end
        end
        e = sb.pop_front();
        chk($sformatf("v%0d done", idx), done, 1);
        chk($sformatf("v%0d stall_cycles", idx), nstall, e.nstall);
        chk($sformatf("v%0d req_cycles", idx), nreq, e.nreq);
        if (e.nreq > 0) chk($sformatf("v%0d bus_fields", idx), bad, 0);
        chk($sformatf("v%0d wb_valid", idx), wb_valid, e.wb);
        if (e.wb) begin
            chk($sformatf("v%0d wb_addr", idx), wb_addr, e.rd);
            chk($sformatf("v%0d wb_data", idx), wb_data, e.data);
        end
        chk($sformatf("v%0d misalign", idx), misalign_exc, e.mis);
        chk($sformatf("v%0d bus_err", idx), bus_err_exc, e.berr);
        mem_wen = 1'b0; mem_ren = 1'b0;
        @(negedge clk);
        #1;
        chk($sformatf("v%0d pulse_clear", idx), {wb_valid, misalign_exc, bus_err_exc, stall}, 0);
    endtask

    initial begin
        int   n;
        logic done;
        vecs[0]  = '{'0, '1, 32'h100, 32'h0, 4'h0, RDT_W, '1, 5'd5, 32'hDEADBEEF, '0, 0, '0,
                     32'h100, '0, 4'hF, 1, 3, '1, 32'hDEADBEEF, '0, '0};
        vecs[1]  = '{'0, '1, 32'h103, 32'h0, 4'h0, RDT_B, '1, 5'd7, 32'h80FF0000, '0, 0, '0,
                     32'h100, '0, 4'hF, 1, 3, '1, 32'hFFFFFF80, '0, '0};
        vecs[2]  = '{'0, '1, 32'h103, 32'h0, 4'h0, RDT_B | RDT_U, '1, 5'd7, 32'h80FF0000, '0, 0, '0,
                     32'h100, '0, 4'hF, 1, 3, '1, 32'h00000080, '0, '0};
        vecs[3]  = '{'1, '0, 32'h202, 32'hABCD0000, 4'hC, 4'h0, '0, 5'd0, 32'h0, '0, 3, '0,
                     32'h200, '1, 4'hC, 4, 6, '0, 32'h0, '0, '0};
        vecs[4]  = '{'0, '1, 32'h101, 32'h0, 4'h0, RDT_W, '1, 5'd5, 32'h11111111, '0, 0, '0,
                     32'h100, '0, 4'hF, 0, 1, '0, 32'h0, '1, '0};
        vecs[5]  = '{'0, '1, 32'h104, 32'h0, 4'h0, RDT_W, '1, 5'd6, 32'h12345678, '1, 0, '0,
                     32'h104, '0, 4'hF, 1, 3, '0, 32'h0, '0, '1};
        vecs[6]  = '{'0, '1, 32'h108, 32'h0, 4'h0, RDT_W, '1, 5'd0, 32'hCAFEF00D, '0, 0, '0,
                     32'h108, '0, 4'hF, 1, 3, '0, 32'h0, '0, '0};
        vecs[7]  = '{'0, '1, 32'h102, 32'h0, 4'h0, RDT_H, '1, 5'd9, 32'h80011234, '0, 1, '1,
                     32'h100, '0, 4'hF, 2, 4, '1, 32'hFFFF8001, '0, '0};
        vecs[8]  = '{'0, '1, 32'h101, 32'h0, 4'h0, RDT_H | RDT_U, '1, 5'd9, 32'h0, '0, 0, '0,
                     32'h100, '0, 4'hF, 0, 1, '0, 32'h0, '1, '0};
        vecs[9]  = '{'1, '0, 32'h003, 32'h5A000000, 4'h8, 4'h0, '0, 5'd0, 32'h0, '0, 0, '0,
                     32'h000, '1, 4'h8, 1, 3, '0, 32'h0, '0, '0};
        vecs[10] = '{'1, '0, 32'h006, 32'h00000001, 4'hF, 4'h0, '0, 5'd0, 32'h0, '0, 0, '0,
                     32'h004, '1, 4'hF, 0, 1, '0, 32'h0, '1, '0};
        vecs[11] = '{'1, '1, 32'h202, 32'hBEEF0000, 4'hC, RDT_W, '1, 5'd3, 32'h77777777, '0, 0, '0,
                     32'h200, '1, 4'hC, 1, 3, '0, 32'h0, '0, '0};
        vecs[12] = '{'0, '1, 32'h101, 32'h0, 4'h0, RDT_B, '1, 5'd10, 32'h00007F00, '0, 0, '0,
                     32'h100, '0, 4'hF, 1, 3, '1, 32'h0000007F, '0, '0};
        vecs[13] = '{'0, '1, 32'h10C, 32'h0, 4'h0, RDT_W, '0, 5'd4, 32'h55AA55AA, '0, 0, '0,
                     32'h10C, '0, 4'hF, 1, 3, '0, 32'h0, '0, '0};
        vecs[14] = '{'0, '1, 32'h100, 32'h0, 4'h0, RDT_H | RDT_U, '1, 5'd31, 32'h1234F00D, '0, 2, '0,
                     32'h100, '0, 4'hF, 3, 5, '1, 32'h0000F00D, '0, '0};

        rst = 1'b1;
        mem_wen = 1'b0; mem_ren = 1'b0; mem_addr = 32'h0; mem_wdata = 32'h0;
        data_be = 4'h0; mem_rdtype = 4'h0; rd_wen = 1'b0; rd_addr = 5'd0;
        bus_req_ready = 1'b0; bus_rsp_valid = 1'b0; bus_rsp_rdata = 32'h0; bus_rsp_err = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset ctrl", {stall, bus_req_valid, bus_we, bus_be, wb_valid, wb_addr, misalign_exc, bus_err_exc}, 0);
        chk("reset data", {bus_addr, bus_wdata, wb_data}, 0);
        chk("reset to ctrl", {t_stall, t_bus_req_valid, t_bus_we, t_bus_be, t_wb_valid, t_wb_addr,
                              t_misalign_exc, t_bus_err_exc}, 0);
        chk("reset to data", {t_bus_addr, t_bus_wdata, t_wb_data}, 0);
        rst = 1'b0;

        // Timeout: dut_to never sees ready, so it must abort after 4 REQ cycles.
        @(negedge clk);
        mem_ren = 1'b1; mem_addr = 32'h100; mem_rdtype = RDT_W; rd_wen = 1'b1; rd_addr = 5'd5;
        n = 0;
        done = 1'b0;
        for (int c = 0; c < 20 && !done; c++) begin
            #1;
            if (!t_stall) done = 1'b1;
            else begin
                if (t_bus_req_valid) n++;
                @(negedge clk);
            end
        end
        chk("timeout done", done, 1);
        chk("timeout req_cycles", n, 4);
        chk("timeout err", t_bus_err_exc, 1);
        chk("timeout req_dropped", t_bus_req_valid, 0);
        chk("timeout no_wb", t_wb_valid, 0);
        mem_ren = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) run(vecs[i], i);

        // Reset while a request is outstanding clears everything at once.
        @(negedge clk);
        mem_ren = 1'b1; mem_addr = 32'h100; mem_rdtype = RDT_W; rd_wen = 1'b1; rd_addr = 5'd5;
        @(negedge clk);
        #1;
        chk("mid req_valid", bus_req_valid, 1);
        rst = 1'b1;
        mem_ren = 1'b0;
        #1;
        chk("mid_rst ctrl", {stall, bus_req_valid, bus_we, bus_be, wb_valid, wb_addr, misalign_exc, bus_err_exc}, 0);
        chk("mid_rst data", {bus_addr, bus_wdata, wb_data}, 0);
        @(negedge clk);
        rst = 1'b0;
        run(vecs[0], 100);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
